// File: rtl/hero_write_arb.sv
// Round-robin arbiter sharing one hero write bus among NUM_REQ requesters.
// A grant is held for a whole VALID*/DONE transaction; the bus is driven from one registered stage.
module hero_write_arb #(
    parameter int NUM_REQ    = 4,
    parameter int HERO_WIDTH = 36,
    parameter int TIMEOUT    = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ*4-1:0]            req_cycle_type,
    input  logic [NUM_REQ*HERO_WIDTH-1:0]   req_wdat,
    input  logic [NUM_REQ-1:0]              req_clk_en,
    output logic [NUM_REQ-1:0]              req_rdy,
    output logic [3:0]                      out_cycle_type,
    output logic [HERO_WIDTH-1:0]           out_wdat,
    output logic                            out_clk_en,
    input  logic                            out_rdy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            timeout_err
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0] CT_IDLE  = 4'd0;
    localparam logic [3:0] CT_VALID = 4'd1;
    localparam logic [3:0] CT_DONE  = 4'd2;

    typedef enum logic {ST_ARB = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              out_ct_q, out_ct_d;
    logic [HERO_WIDTH-1:0]   out_wd_q, out_wd_d;
    logic                    out_ce_q, out_ce_d;
    logic                    tout_q, tout_d;

    logic [NUM_REQ-1:0]      requesting;
    logic [GW-1:0]           win, idx;
    logic                    found;
    logic [3:0]              g_ct;
    logic [HERO_WIDTH-1:0]   g_wd;
    logic                    g_ce;
    logic                    free, accept;

    // Reserved encodings (0, 3..15) never count as a request.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            requesting[i] = (req_cycle_type[i*4 +: 4] == CT_VALID) ||
                            (req_cycle_type[i*4 +: 4] == CT_DONE);
        end
    end

    always_comb begin
        win   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_q) + k) % NUM_REQ);
            if (!found && requesting[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign g_ct   = req_cycle_type[int'(grant_q)*4 +: 4];
    assign g_wd   = req_wdat[int'(grant_q)*HERO_WIDTH +: HERO_WIDTH];
    assign g_ce   = req_clk_en[grant_q];
    assign free   = (out_ct_q == CT_IDLE) || out_rdy;
    assign accept = (state_q == ST_BUSY) && free && requesting[grant_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        out_ct_d = out_ct_q;
        out_wd_d = out_wd_q;
        out_ce_d = out_ce_q;
        tout_d   = 1'b0;
        req_rdy  = '0;

        if (!rst && state_q == ST_BUSY && free) begin
            req_rdy[grant_q] = 1'b1;
        end

        // A free stage takes the accepted beat, otherwise a bubble.
        if (free) begin
            out_ct_d = CT_IDLE;
            out_wd_d = '0;
            out_ce_d = 1'b0;
            if (accept) begin
                out_ct_d = g_ct;
                out_wd_d = g_wd;
                out_ce_d = g_ce;
            end
        end

        case (state_q)
            ST_ARB: begin
                if (|requesting) begin
                    grant_d = win;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    cnt_d = '0;
                    if (g_ct == CT_DONE) begin
                        last_d  = grant_q;
                        state_d = ST_ARB;
                    end
                end else if (free && TIMEOUT != 0) begin
                    // Only idle cycles with a free stage count towards the timeout.
                    if (cnt_q == TO_LAST) begin
                        tout_d  = 1'b1;
                        last_d  = grant_q;
                        cnt_d   = '0;
                        state_d = ST_ARB;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARB;
            grant_q  <= '0;
            last_q   <= GW'(NUM_REQ - 1);
            cnt_q    <= '0;
            out_ct_q <= CT_IDLE;
            out_wd_q <= '0;
            out_ce_q <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            out_ct_q <= out_ct_d;
            out_wd_q <= out_wd_d;
            out_ce_q <= out_ce_d;
            tout_q   <= tout_d;
        end
    end

    assign out_cycle_type = out_ct_q;
    assign out_wdat       = out_wd_q;
    assign out_clk_en     = out_ce_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q == ST_BUSY);
    assign timeout_err    = tout_q;
endmodule

// File: tb/tb_hero_write_arb.sv
// Testbench for hero_write_arb: a per-cycle vector table plus scoreboarded multi-cycle scenarios.
module tb_hero_write_arb;
    localparam int NR = 4;
    localparam int W  = 36;
    localparam logic [3:0] CT_IDLE  = 4'd0;
    localparam logic [3:0] CT_VALID = 4'd1;
    localparam logic [3:0] CT_DONE  = 4'd2;

    logic              clk, rst;
    logic [NR*4-1:0]   req_cycle_type;
    logic [NR*W-1:0]   req_wdat;
    logic [NR-1:0]     req_clk_en;
    logic [NR-1:0]     req_rdy;
    logic [3:0]        out_cycle_type;
    logic [W-1:0]      out_wdat;
    logic              out_clk_en;
    logic              out_rdy;
    logic [1:0]        grant_id;
    logic              busy, timeout_err;

    hero_write_arb #(.NUM_REQ(NR), .HERO_WIDTH(W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_cycle_type(req_cycle_type), .req_wdat(req_wdat), .req_clk_en(req_clk_en),
        .req_rdy(req_rdy),
        .out_cycle_type(out_cycle_type), .out_wdat(out_wdat), .out_clk_en(out_clk_en),
        .out_rdy(out_rdy),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ct;
        logic [W-1:0] wd;
        logic        ce;
    } beat_t;

    typedef struct packed {
        logic [15:0]  ct;
        logic [143:0] wd;
        logic [3:0]   ce;
        logic         ordy;
        logic [3:0]   e_ct;
        logic [W-1:0] e_wd;
        logic         e_ce;
        logic         e_busy;
        logic [1:0]   e_gid;
        logic [3:0]   e_rdy;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  tbl[9];
    beat_t src_q[NR][$];
    int    start_at[NR];
    beat_t sb_q[$];
    int    done_order[$];
    int    cons_cyc[$];
    int    to_pulses, to_cyc;
    logic  busy_at_to;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [15:0] ct, input logic [143:0] wd, input logic [3:0] ce,
                                 input logic ordy, input logic [3:0] e_ct, input logic [W-1:0] e_wd,
                                 input logic e_ce, input logic e_busy, input logic [1:0] e_gid,
                                 input logic [3:0] e_rdy);
        vec_t v;
        v.ct = ct; v.wd = wd; v.ce = ce; v.ordy = ordy;
        v.e_ct = e_ct; v.e_wd = e_wd; v.e_ce = e_ce; v.e_busy = e_busy; v.e_gid = e_gid; v.e_rdy = e_rdy;
        return v;
    endfunction

    function automatic beat_t mkb(input logic [3:0] ct, input logic [W-1:0] wd, input logic ce);
        beat_t b;
        b.ct = ct; b.wd = wd; b.ce = ce;
        return b;
    endfunction

    task automatic idle_inputs();
        req_cycle_type = '0;
        req_wdat       = '0;
        req_clk_en     = '0;
        out_rdy        = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete();
            start_at[i] = 0;
        end
    endtask

    // One cycle per iteration: drive source heads, consume out beats, record accepts.
    task automatic run(input int ncyc, input int lo_s, input int lo_e);
        beat_t        hb[NR];
        bit           pres[NR];
        logic [15:0]  ct_v;
        logic [143:0] wd_v;
        logic [3:0]   ce_v, gmask;
        logic [3:0]   pct;
        logic [W-1:0] pwd;
        logic         pce, pordy;
        beat_t        exp_b;
        done_order.delete();
        cons_cyc.delete();
        to_pulses  = 0;
        to_cyc     = -1;
        busy_at_to = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            ct_v = '0; wd_v = '0; ce_v = '0;
            for (int i = 0; i < NR; i++) begin
                pres[i] = (c >= start_at[i]) && (src_q[i].size() > 0);
                hb[i]   = pres[i] ? src_q[i][0] : '0;
                ct_v[i*4 +: 4] = hb[i].ct;
                wd_v[i*W +: W] = hb[i].wd;
                ce_v[i]        = hb[i].ce;
            end
            req_cycle_type = ct_v;
            req_wdat       = wd_v;
            req_clk_en     = ce_v;
            out_rdy        = !(c >= lo_s && c <= lo_e);
            #1;
            if (timeout_err) begin
                to_pulses++;
                to_cyc     = c;
                busy_at_to = busy;
            end
            if (out_cycle_type != CT_IDLE && out_rdy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_beat", out_cycle_type, CT_IDLE);
                end else begin
                    exp_b = sb_q.pop_front();
                    chk($sformatf("sb_ct c%0d", c), out_cycle_type, exp_b.ct);
                    chk($sformatf("sb_wdat c%0d", c), out_wdat, exp_b.wd);
                    chk($sformatf("sb_clk_en c%0d", c), out_clk_en, exp_b.ce);
                    cons_cyc.push_back(c);
                end
            end
            gmask = busy ? (4'b0001 << grant_id) : 4'b0000;
            chk($sformatf("rdy_only_granted c%0d", c), req_rdy & ~gmask, 0);
            if (out_cycle_type != CT_IDLE && !out_rdy)
                chk($sformatf("rdy_low_when_stalled c%0d", c), req_rdy, 0);
            for (int i = 0; i < NR; i++) begin
                if (req_rdy[i] && pres[i]) begin
                    sb_q.push_back(hb[i]);
                    if (hb[i].ct == CT_DONE) done_order.push_back(i);
                    void'(src_q[i].pop_front());
                end
            end
            pct = out_cycle_type; pwd = out_wdat; pce = out_clk_en; pordy = out_rdy;
            @(posedge clk);
            #1;
            if (pct != CT_IDLE && !pordy) begin
                chk($sformatf("hold_ct c%0d", c), out_cycle_type, pct);
                chk($sformatf("hold_wdat c%0d", c), out_wdat, pwd);
                chk($sformatf("hold_clk_en c%0d", c), out_clk_en, pce);
            end
        end
    endtask

    task automatic chk_order(input string nm, input int n, input logic [63:0] ids);
        chk({nm, " done_count"}, done_order.size(), n);
        for (int k = 0; k < n && k < done_order.size(); k++)
            chk($sformatf("%s grant#%0d", nm, k), done_order[k], ids[k*4 +: 4]);
    endtask

    task automatic chk_cycles(input string nm, input int n, input logic [63:0] cyc);
        chk({nm, " beat_count"}, cons_cyc.size(), n);
        for (int k = 0; k < n && k < cons_cyc.size(); k++)
            chk($sformatf("%s beat#%0d cycle", nm, k), cons_cyc[k], cyc[k*8 +: 8]);
    endtask

    task automatic chk_drained(input string nm);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s src%0d drained", nm, i), src_q[i].size(), 0);
        chk({nm, " scoreboard empty"}, sb_q.size(), 0);
    endtask

    initial begin
        // Single requester 2: VALID 1, VALID 2, DONE 3, then reserved encodings 3 and 15.
        tbl[0] = mkv(16'h0100, {36'h0, 36'h1, 72'h0}, 4'b0100, 1'b1, CT_IDLE,  36'h0, 1'b0, 1'b0, 2'd0, 4'b0000);
        tbl[1] = mkv(16'h0100, {36'h0, 36'h1, 72'h0}, 4'b0100, 1'b1, CT_IDLE,  36'h0, 1'b0, 1'b1, 2'd2, 4'b0100);
        tbl[2] = mkv(16'h0100, {36'h0, 36'h2, 72'h0}, 4'b0000, 1'b1, CT_VALID, 36'h1, 1'b1, 1'b1, 2'd2, 4'b0100);
        tbl[3] = mkv(16'h0200, {36'h0, 36'h3, 72'h0}, 4'b0100, 1'b1, CT_VALID, 36'h2, 1'b0, 1'b1, 2'd2, 4'b0100);
        tbl[4] = mkv(16'h0000, 144'h0,                 4'b0000, 1'b1, CT_DONE,  36'h3, 1'b1, 1'b0, 2'd2, 4'b0000);
        tbl[5] = mkv(16'h0000, 144'h0,                 4'b0000, 1'b1, CT_IDLE,  36'h0, 1'b0, 1'b0, 2'd2, 4'b0000);
        tbl[6] = mkv(16'h0003, {108'h0, 36'h55},       4'b0001, 1'b1, CT_IDLE,  36'h0, 1'b0, 1'b0, 2'd2, 4'b0000);
        tbl[7] = mkv(16'h000F, {108'h0, 36'h56},       4'b0001, 1'b1, CT_IDLE,  36'h0, 1'b0, 1'b0, 2'd2, 4'b0000);
        tbl[8] = mkv(16'h0000, 144'h0,                 4'b0000, 1'b1, CT_IDLE,  36'h0, 1'b0, 1'b0, 2'd2, 4'b0000);

        clear_sources();
        do_reset();
        chk("reset out_ct", out_cycle_type, CT_IDLE);
        chk("reset out_wdat", out_wdat, 0);
        chk("reset out_clk_en", out_clk_en, 0);
        chk("reset req_rdy", req_rdy, 0);
        chk("reset grant_id", grant_id, 0);
        chk("reset busy", busy, 0);
        chk("reset timeout_err", timeout_err, 0);

        for (int r = 0; r < 9; r++) begin
            req_cycle_type = tbl[r].ct;
            req_wdat       = tbl[r].wd;
            req_clk_en     = tbl[r].ce;
            out_rdy        = tbl[r].ordy;
            #1;
            chk($sformatf("tbl%0d out_ct", r), out_cycle_type, tbl[r].e_ct);
            if (tbl[r].e_ct != CT_IDLE) begin
                chk($sformatf("tbl%0d out_wdat", r), out_wdat, tbl[r].e_wd);
                chk($sformatf("tbl%0d out_clk_en", r), out_clk_en, tbl[r].e_ce);
            end
            chk($sformatf("tbl%0d busy", r), busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d grant_id", r), grant_id, tbl[r].e_gid);
            chk($sformatf("tbl%0d req_rdy", r), req_rdy, tbl[r].e_rdy);
            chk($sformatf("tbl%0d timeout_err", r), timeout_err, 0);
            @(posedge clk);
            #1;
        end

        // Contention: every requester offers two single-beat DONE transactions from reset.
        do_reset();
        clear_sources();
        for (int i = 0; i < NR; i++) begin
            src_q[i].push_back(mkb(CT_DONE, W'((i << 8) | 1), i[0]));
            src_q[i].push_back(mkb(CT_DONE, W'((i << 8) | 2), ~i[0]));
        end
        run(20, -1, -2);
        chk_order("contention", 8, 64'h32103210);
        chk_cycles("contention", 8, 64'h100E0C0A08060402);
        chk_drained("contention");

        // Backpressure: out_rdy low for cycles 2..6 while VALID 0xAA sits on the bus.
        do_reset();
        clear_sources();
        src_q[2].push_back(mkb(CT_VALID, 36'hAA, 1'b1));
        src_q[2].push_back(mkb(CT_VALID, 36'hBB, 1'b0));
        src_q[2].push_back(mkb(CT_DONE,  36'hCC, 1'b1));
        run(12, 2, 6);
        chk_order("backpressure", 1, 64'h2);
        chk_cycles("backpressure", 3, 64'h090807);
        chk_drained("backpressure");

        // Lock: requester 1 mid-transaction while requester 0 joins at cycle 2.
        do_reset();
        clear_sources();
        src_q[1].push_back(mkb(CT_VALID, 36'hA1, 1'b1));
        src_q[1].push_back(mkb(CT_VALID, 36'hA2, 1'b0));
        src_q[1].push_back(mkb(CT_VALID, 36'hA3, 1'b1));
        src_q[1].push_back(mkb(CT_DONE,  36'hA4, 1'b0));
        src_q[0].push_back(mkb(CT_DONE,  36'hE0, 1'b1));
        start_at[0] = 2;
        run(10, -1, -2);
        chk_order("lock", 2, 64'h01);
        chk_cycles("lock", 5, 64'h0705040302);
        chk_drained("lock");

        // Timeout (no reset, last winner 0): req 3 sends VALID then goes idle.
        clear_sources();
        src_q[3].push_back(mkb(CT_VALID, 36'h5, 1'b0));
        src_q[0].push_back(mkb(CT_DONE, 36'h10, 1'b1));
        src_q[1].push_back(mkb(CT_DONE, 36'h11, 1'b1));
        start_at[0] = 6;
        start_at[1] = 6;
        run(13, -1, -2);
        chk("timeout pulses", to_pulses, 1);
        chk("timeout cycle", to_cyc, 6);
        chk("timeout busy", busy_at_to, 0);
        chk_order("timeout", 2, 64'h10);
        chk_cycles("timeout", 3, 64'h0A0802);
        chk_drained("timeout");

        // Same stall with out_rdy low throughout: no timeout, the beat stays held.
        do_reset();
        clear_sources();
        src_q[3].push_back(mkb(CT_VALID, 36'h6, 1'b1));
        run(15, 0, 1000);
        chk("no_timeout pulses", to_pulses, 0);
        chk("no_timeout busy", busy, 1);
        chk("no_timeout out_ct", out_cycle_type, CT_VALID);
        chk("no_timeout out_wdat", out_wdat, 36'h6);
        sb_q.delete();

        // Reset while busy with VALID held on the bus.
        rst            = 1'b1;
        req_cycle_type = 16'h1000;
        req_wdat       = {36'h7, 108'h0};
        req_clk_en     = 4'b1000;
        out_rdy        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst out_ct", out_cycle_type, CT_IDLE);
        chk("midrst busy", busy, 0);
        chk("midrst req_rdy", req_rdy, 0);
        chk("midrst grant_id", grant_id, 0);
        chk("midrst timeout_err", timeout_err, 0);
        clear_sources();
        src_q[3].push_back(mkb(CT_DONE, 36'h23, 1'b0));
        src_q[0].push_back(mkb(CT_DONE, 36'h20, 1'b1));
        run(8, -1, -2);
        chk_order("post_reset", 2, 64'h30);
        chk_cycles("post_reset", 2, 64'h0402);
        chk_drained("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hero_write_arb.md
Name: hero_write_arb

Overview:
- Round-robin arbiter that shares one hero write bus among NUM_REQ requesters.
- Each requester drives a hero_write beat: cycle_type, wdat and clk_en.
- A grant is locked for a whole transaction, which is zero or more VALID beats closed by one DONE beat.
- Sits in front of the single hero bus consumer and drives it through one registered output stage with backpressure.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- HERO_WIDTH, 36: wdat width per beat.
- TIMEOUT, 64: consecutive stalled cycles of a granted requester before forced release; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_cycle_type  in  NUM_REQ*4  per-requester cycle_type; encoding IDLE=0, VALID=1, DONE=2.
- req_wdat  in  NUM_REQ*HERO_WIDTH  per-requester write data.
- req_clk_en  in  NUM_REQ  per-requester clock enable field.
- req_rdy  out  NUM_REQ  beat accepted from requester i this cycle when high and req_cycle_type[i] is non-IDLE.
- out_cycle_type  out  4  registered bus cycle_type.
- out_wdat  out  HERO_WIDTH  registered bus data.
- out_clk_en  out  1  registered bus clock enable.
- out_rdy  in  1  consumer accepts the current out beat.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  a transaction is locked.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (clk and rst are fixed: one clock; reset is synchronous and active-high):
  - Outputs: out_cycle_type=IDLE, out_wdat=0, out_clk_en=0, req_rdy=0, grant_id=0, busy=0, timeout_err=0.
  - State returns to ARB; the round-robin pointer is set so requester 0 has top priority.
  - Reset mid-transaction discards the in-flight beat and the lock immediately.
- Request decoding: requester i requests when req_cycle_type[i] is VALID or DONE. Values 0 and 3..15 are treated as IDLE and are never forwarded.
- States: ARB, BUSY.
- ARB:
  - req_rdy=0.
  - If any requester requests, pick the first requesting index strictly after the last winner (wrapping), then register grant_id and busy=1, and go to BUSY.
  - Arbitration costs exactly 1 cycle.
- BUSY, output stage: the stage is "free" when out_cycle_type==IDLE or out_rdy==1.
- BUSY, req_rdy[grant_id] = free. All other req_rdy bits are 0.
- BUSY, beat accepted (req_rdy[g] && requesting[g]):
  - The beat is loaded into the out registers next cycle.
  - If the beat is DONE: busy=0, the winner is recorded as last winner, and the state goes to ARB.
  - Minimum gap between transactions is one ARB cycle; back-to-back DONE/DONE from different requesters appear on out at most every 2 cycles.
- BUSY, stage free but no beat accepted: load IDLE into out, so bubbles propagate as IDLE.
- Output hold: when out_cycle_type!=IDLE and out_rdy==0, all out registers hold their values.
- Latency: accepted beat to out is 1 cycle. Requester first asserting to first acceptance is 1 cycle when uncontended.
- Timeout:
  - In BUSY, a counter increments each cycle the granted requester presents IDLE. It clears on every accepted beat and on entering BUSY.
  - When the counter reaches TIMEOUT: pulse timeout_err, go to ARB, and record the winner as last winner.
  - Cycles stalled by out_rdy==0 do not count.
- Ungranted requesters must hold their beat stable until accepted; the arbiter never drops or reorders beats within a transaction.
- Simultaneous events:
  - A DONE accept and a new request in the same cycle: the new request is arbitrated in the following ARB cycle.
  - Pointer update and counter clear on the same edge as a DONE accept.

Test Plan:
- Single requester: req 2 sends VALID,VALID,DONE with wdat 0x1,0x2,0x3 and out_rdy=1 -> ARB at cycle 0; out shows VALID 0x1, VALID 0x2, DONE 0x3 at cycles 2,3,4; grant_id=2; busy falls after the DONE accept.
- Contention, NUM_REQ=4: all four request single-beat DONE transactions continuously from reset -> grant order 0,1,2,3,0; one DONE on out every 2 cycles; no beat lost.
- Lock: req 1 granted and mid-transaction, req 0 requesting -> req_rdy[0] stays 0 until req 1's DONE is accepted; req 0 granted next.
- Backpressure: out_rdy low for 5 cycles while out holds VALID 0xAA -> out_cycle_type, out_wdat and out_clk_en are unchanged; req_rdy=0; the next beat appears on the cycle after out_rdy rises.
- Timeout, TIMEOUT=4: granted req 3 sends VALID then IDLE -> timeout_err pulses once 4 cycles later; busy=0; next arbitration starts from req 0. Repeating the test with out_rdy=0 throughout produces no timeout.
- Reset mid-transaction: assert rst while BUSY with out holding VALID -> next cycle out_cycle_type=IDLE, busy=0, req_rdy=0, and requester 0 wins the first post-reset arbitration.
